// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue: FSM encoding,
// queue entry layout, PC step and the NOP word.
package inst_fetch_queue_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_STALL   = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INCR  = 32'd4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Core-redirect, instruction-memory and instruction-delivery signals of the
// fetch queue; master is the fetch unit, slave is its environment.
interface inst_fetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    input  redirect, redirect_pc, mem_ack, mem_rdata, inst_ready,
    output mem_req, mem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, mem_ack, mem_rdata, inst_ready,
    input  mem_req, mem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Circular queue of {pc, word} entries with flush priority; the head entry is
// read straight from the storage registers.
module fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     entry_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output fetch_entry_t     head_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: storage is reset so the head presents a NOP at pc 0 out of reset; cheap at this depth.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{pc: '0, word: NOP_WORD};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register reading its pre-edge value here.
      if (do_push) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: FETCH/STALL/DISCARD request FSM and fetch PC in
// front of a small in-order instruction queue.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_queue_if.master bus
);

  localparam int               CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(DEPTH - 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      hold_addr_q, hold_addr_d;
  logic             push, pop, full, empty;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;

  assign pop = bus.inst_valid && bus.inst_ready;

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    hold_addr_d = hold_addr_q;
    push        = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (bus.redirect) begin
          fetch_pc_d = align_pc(bus.redirect_pc);
          if (!bus.mem_ack) begin
            state_d     = ST_DISCARD;
            hold_addr_d = fetch_pc_q;
          end
        end else if (bus.mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_INCR;
          // Stall only if this push fills the last slot with nothing leaving.
          if (count == LAST_C && !pop) state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (bus.redirect) begin
          fetch_pc_d = align_pc(bus.redirect_pc);
          state_d    = ST_FETCH;
        end else if (!full || pop) begin
          state_d = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        // The old request stays on the bus until its ack, which is thrown away.
        if (bus.redirect) fetch_pc_d = align_pc(bus.redirect_pc);
        if (bus.mem_ack) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FETCH;
      fetch_pc_q  <= RESET_PC;
      hold_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.redirect),
    .push_i  (push),
    .entry_i ('{pc: fetch_pc_q, word: bus.mem_rdata}),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .head_o  (head)
  );

  assign bus.mem_req    = (state_q != ST_STALL);
  assign bus.mem_addr   = (state_q == ST_DISCARD) ? hold_addr_q : fetch_pc_q;
  assign bus.inst_valid = !empty;
  assign bus.inst       = head.word;
  assign bus.inst_pc    = head.pc;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: streaming, stall/restart, redirect and
// discard, PC wrap and asynchronous reset, with hand-computed expectations.
module tb_inst_fetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  inst_fetch_queue_if fq ();

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fq.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic red, input logic [31:0] rpc, input logic ack,
                       input logic [31:0] rdata, input logic rdy);
    fq.redirect    = red;
    fq.redirect_pc = rpc;
    fq.mem_ack     = ack;
    fq.mem_rdata   = rdata;
    fq.inst_ready  = rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a response in flight.
    drive(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    step(); step();
    check("rst_valid", 32'(fq.inst_valid), 32'd0);
    check("rst_inst",  fq.inst,            32'h0);
    check("rst_pc",    fq.inst_pc,         32'h0);
    check("rst_req",   32'(fq.mem_req),    32'd1);
    check("rst_addr",  fq.mem_addr,        32'h0);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    check("idle_valid", 32'(fq.inst_valid), 32'd0);
    check("idle_addr",  fq.mem_addr,        32'h0);

    // Back-to-back acks with the core always ready.
    drive(1'b0, 32'h0, 1'b1, word_at(32'h0), 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("stream_valid", 32'(fq.inst_valid), 32'd1);
      check("stream_pc",    fq.inst_pc,         32'(4 * (k - 1)));
      check("stream_inst",  fq.inst,            word_at(32'(4 * (k - 1))));
      check("stream_addr",  fq.mem_addr,        32'(4 * k));
      fq.mem_rdata = word_at(32'(4 * k));
    end

    // Core stalls: queue holds 12 and fills with 16, 20, 24.
    fq.inst_ready = 1'b0;
    step();
    check("fill_req1",  32'(fq.mem_req), 32'd1);
    check("fill_addr1", fq.mem_addr,     32'd20);
    fq.mem_rdata = word_at(32'd20);
    step();
    check("fill_addr2", fq.mem_addr, 32'd24);
    fq.mem_rdata = word_at(32'd24);
    step();
    check("full_req",   32'(fq.mem_req),    32'd0);
    check("full_valid", 32'(fq.inst_valid), 32'd1);
    check("full_pc",    fq.inst_pc,         32'd12);
    fq.mem_ack = 1'b0;
    step();
    check("stall_hold_req", 32'(fq.mem_req), 32'd0);
    check("stall_hold_pc",  fq.inst_pc,      32'd12);
    fq.inst_ready = 1'b1;
    step();
    check("restart_req",  32'(fq.mem_req), 32'd1);
    check("restart_addr", fq.mem_addr,     32'd28);
    check("order_pc16",   fq.inst_pc,      32'd16);
    check("order_w16",    fq.inst,         word_at(32'd16));
    step();
    check("order_pc20", fq.inst_pc, 32'd20);
    step();
    check("order_pc24", fq.inst_pc,  32'd24);
    check("order_w24",  fq.inst,     word_at(32'd24));
    check("addr_stable", fq.mem_addr, 32'd28);
    step();
    check("drained_valid", 32'(fq.inst_valid), 32'd0);

    // Redirect together with an ack: response dropped, fetch goes straight to 8.
    drive(1'b1, 32'h8, 1'b1, word_at(32'd28), 1'b0);
    step();
    check("redir_ack_valid", 32'(fq.inst_valid), 32'd0);
    check("redir_ack_addr",  fq.mem_addr,        32'h8);

    // Redirect while the request to 8 is still waiting: DISCARD holds address 8.
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    step();
    fq.redirect = 1'b0;
    check("discard_addr1", fq.mem_addr,      32'h8);
    check("discard_req",   32'(fq.mem_req),  32'd1);
    step();
    check("discard_addr2", fq.mem_addr, 32'h8);
    step();
    check("discard_addr3", fq.mem_addr, 32'h8);
    drive(1'b0, 32'h0, 1'b1, word_at(32'h8), 1'b0);
    step();
    check("discard_drop_valid", 32'(fq.inst_valid), 32'd0);
    check("discard_new_addr",   fq.mem_addr,        32'h100);
    fq.mem_rdata = word_at(32'h100);
    step();
    check("after_discard_pc",   fq.inst_pc,  32'h100);
    check("after_discard_inst", fq.inst,     word_at(32'h100));
    check("after_discard_addr", fq.mem_addr, 32'h104);
    fq.mem_rdata = word_at(32'h104);
    step();
    fq.mem_rdata = word_at(32'h108);
    step();
    check("three_entries_addr", fq.mem_addr, 32'h10C);

    // Redirect, push and pop in one cycle with three queued entries.
    drive(1'b1, 32'h0000_2002, 1'b1, word_at(32'h10C), 1'b1);
    step();
    check("flush_valid", 32'(fq.inst_valid), 32'd0);
    check("flush_addr",  fq.mem_addr,        32'h2000);
    check("flush_req",   32'(fq.mem_req),    32'd1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    check("flush_no_push", 32'(fq.inst_valid), 32'd0);

    // Fetch PC wraps from the top of the address space.
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0, 1'b0);
    step();
    check("wrap_start", fq.mem_addr, 32'hFFFF_FFFC);
    drive(1'b0, 32'h0, 1'b1, word_at(32'hFFFF_FFFC), 1'b0);
    step();
    check("wrap_addr", fq.mem_addr, 32'h0);
    check("wrap_pc",   fq.inst_pc,  32'hFFFF_FFFC);
    check("wrap_inst", fq.inst,     word_at(32'hFFFF_FFFC));
    fq.mem_rdata = word_at(32'h0);
    step();
    fq.mem_rdata = word_at(32'h4);
    step();
    fq.mem_rdata = word_at(32'h8);
    step();
    check("wrap_full_req", 32'(fq.mem_req), 32'd0);
    fq.mem_ack = 1'b0;

    // Asynchronous reset mid-cycle with a full queue.
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(fq.inst_valid), 32'd0);
    check("async_rst_req",   32'(fq.mem_req),    32'd1);
    check("async_rst_addr",  fq.mem_addr,        32'h0);
    drive(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    step();
    rst = 1'b1;
    fq.mem_ack = 1'b0;
    step();
    check("post_rst_valid", 32'(fq.inst_valid), 32'd0);

    // Reset in the middle of DISCARD, with a late ack arriving during reset.
    drive(1'b0, 32'h0, 1'b1, word_at(32'h0), 1'b0);
    step();
    check("pre_discard_addr", fq.mem_addr, 32'h4);
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    step();
    fq.redirect = 1'b0;
    check("rst_discard_addr", fq.mem_addr, 32'h4);
    #2 rst = 1'b0;
    #1;
    check("rst_discard_valid", 32'(fq.inst_valid), 32'd0);
    check("rst_discard_raddr", fq.mem_addr,        32'h0);
    drive(1'b0, 32'h0, 1'b1, word_at(32'h4), 1'b0);
    step();
    rst = 1'b1;
    fq.mem_ack = 1'b0;
    step();
    check("late_ack_valid", 32'(fq.inst_valid), 32'd0);
    check("late_ack_addr",  fq.mem_addr,        32'h0);
    check("late_ack_req",   32'(fq.mem_req),    32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
